div_unit: RTL and testbench

- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the execute stage between the register file read ports and the writeback path.
- Consumes rs1/rs2 operand data plus a destination tag, and returns the quotient or remainder with that tag for a register-file write.
- Multi-cycle; uses a valid/ready handshake on both sides so the pipeline can stall around it.

---
 rtl/div_pkg.sv | 12 +
 rtl/div_if.sv | 28 ++
 rtl/div_step.sv | 22 ++
 rtl/div_unit.sv | 110 +++++++++++
 tb/tb_div_unit.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the iterative divider
//   div_op_t    : funct3[1:0] encoding of DIV/DIVU/REM/REMU
//   div_state_t : divider control states
//   twos_neg    : two's-complement negation, MAX_W bits wide; callers truncate
package div_pkg;
  localparam int MAX_W = 64;
  typedef enum logic [1:0] {DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11} div_op_t;
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
  function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] a);
    return ~a + 1'b1;
  endfunction
endpackage

// File: rtl/div_if.sv
// div_if: request/result handshake bundle for div_unit
//   request : valid_in, ready_out, op_in, rs1_data_in, rs2_data_in, rd_in
//   result  : valid_out, ready_in, result_out, rd_out
//   master drives requests and accepts results; slave is the divider
interface div_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGISTERS = 32
);
  localparam int OP_ADDR_WIDTH = $clog2(NUM_REGISTERS);
  logic valid_in;
  logic ready_out;
  logic [1:0] op_in;
  logic [DATA_WIDTH-1:0] rs1_data_in;
  logic [DATA_WIDTH-1:0] rs2_data_in;
  logic [OP_ADDR_WIDTH-1:0] rd_in;
  logic valid_out;
  logic ready_in;
  logic [DATA_WIDTH-1:0] result_out;
  logic [OP_ADDR_WIDTH-1:0] rd_out;
  modport master (
    output valid_in, op_in, rs1_data_in, rs2_data_in, rd_in, ready_in,
    input ready_out, valid_out, result_out, rd_out
  );
  modport slave (
    input valid_in, op_in, rs1_data_in, rs2_data_in, rd_in, ready_in,
    output ready_out, valid_out, result_out, rd_out
  );
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration
//   rem_in/quo_in/dvs_in : partial remainder, shifting quotient, divisor
//   rem_out/quo_out      : values after one shift-compare-subtract step
module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem_in,
  input  logic [DATA_WIDTH-1:0] quo_in,
  input  logic [DATA_WIDTH-1:0] dvs_in,
  output logic [DATA_WIDTH-1:0] rem_out,
  output logic [DATA_WIDTH-1:0] quo_out
);
  logic [DATA_WIDTH:0] sh;
  logic ge;
  always_comb begin
    // one extra bit: the shifted remainder can exceed DATA_WIDTH bits
    sh = {rem_in, quo_in[DATA_WIDTH-1]};
    ge = sh >= {1'b0, dvs_in};
    rem_out = ge ? DATA_WIDTH'(sh - {1'b0, dvs_in}) : sh[DATA_WIDTH-1:0];
    quo_out = {quo_in[DATA_WIDTH-2:0], ge};
  end
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
//   clk, arst_n (async active-low), flush_in (sync abort)
//   bus : div_if.slave request/result handshake with destination tag
//   DIV_EARLY_OUT_EN : divide-by-zero and signed overflow finish after one cycle
module div_unit
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGISTERS = 32
) (
  input logic clk,
  input logic arst_n,
  input logic flush_in,
  div_if.slave bus
);
  localparam int OP_ADDR_WIDTH = $clog2(NUM_REGISTERS);
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  div_state_t state_q, state_d;
  div_op_t op_q, op_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d, spec_q, spec_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [DATA_WIDTH-1:0] spec_val_q, spec_val_d, res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_ADDR_WIDTH-1:0] rd_q, rd_d, rd_out_q, rd_out_d;
  logic [DATA_WIDTH-1:0] rem_n, quo_n, abs1, abs2, q_fin, r_fin, res_fin;
  logic accept, calc, fin, early, s1, s2, div0, ovf;
  div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem_in(rem_q), .quo_in(quo_q), .dvs_in(dvs_q),
    .rem_out(rem_n), .quo_out(quo_n)
  );
`ifdef DIV_EARLY_OUT_EN
  assign early = spec_q;
`else
  assign early = 1'b0;
`endif
  always_comb begin
    accept = state_q == IDLE && bus.valid_in && !flush_in;
    calc = state_q == CALC;
    fin = calc && (cnt_q == LAST || early);
    s1 = !bus.op_in[0] && bus.rs1_data_in[DATA_WIDTH-1];
    s2 = !bus.op_in[0] && bus.rs2_data_in[DATA_WIDTH-1];
    abs1 = s1 ? DATA_WIDTH'(twos_neg(MAX_W'(bus.rs1_data_in))) : bus.rs1_data_in;
    abs2 = s2 ? DATA_WIDTH'(twos_neg(MAX_W'(bus.rs2_data_in))) : bus.rs2_data_in;
    div0 = bus.rs2_data_in == '0;
    ovf = !bus.op_in[0] && bus.rs1_data_in == MOST_NEG && bus.rs2_data_in == '1;
    q_fin = qneg_q ? DATA_WIDTH'(twos_neg(MAX_W'(quo_n))) : quo_n;
    r_fin = rneg_q ? DATA_WIDTH'(twos_neg(MAX_W'(rem_n))) : rem_n;
    res_fin = spec_q ? spec_val_q : (op_q inside {REM, REMU}) ? r_fin : q_fin;
  end
  always_comb begin
    op_d = accept ? div_op_t'(bus.op_in) : op_q;
    qneg_d = accept ? s1 ^ s2 : qneg_q;
    rneg_d = accept ? s1 : rneg_q;
    dvs_d = accept ? abs2 : dvs_q;
    rem_d = accept ? '0 : calc ? rem_n : rem_q;
    quo_d = accept ? abs1 : calc ? quo_n : quo_q;
    cnt_d = accept ? '0 : calc ? cnt_q + 1'b1 : cnt_q;
    spec_d = accept ? div0 || ovf : spec_q;
    spec_val_d = !accept ? spec_val_q :
                 div0 ? (bus.op_in[1] ? bus.rs1_data_in : '1) :
                 (bus.op_in[1] ? '0 : bus.rs1_data_in);
    rd_d = accept ? bus.rd_in : rd_q;
    res_d = fin ? res_fin : res_q;
    rd_out_d = fin ? rd_q : rd_out_q;
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      op_q <= DIV;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dvs_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      spec_q <= 1'b0;
      spec_val_q <= '0;
      rd_q <= '0;
      res_q <= '0;
      rd_out_q <= '0;
    end else begin
      op_q <= op_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dvs_q <= dvs_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      spec_q <= spec_d;
      spec_val_q <= spec_val_d;
      rd_q <= rd_d;
      res_q <= res_d;
      rd_out_q <= rd_out_d;
    end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = flush_in ? IDLE :
              accept ? CALC :
              fin ? DONE :
              (state_q == DONE && bus.ready_in) ? IDLE : state_q;
  always_comb begin
    bus.ready_out = state_q == IDLE;
    bus.valid_out = state_q == DONE;
    bus.result_out = res_q;
    bus.rd_out = rd_out_q;
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit with directed vectors
module tb_div_unit;
  import div_pkg::*;
`ifdef DIV_EARLY_OUT_EN
  localparam int SPL = 1;
`else
  localparam int SPL = 32;
`endif
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic flush_in = 1'b0;
  int total = 0;
  int bad = 0;
  logic [36:0] sb[$];
  logic [36:0] mon_e;
  always #5 clk = ~clk;
  div_if #(.DATA_WIDTH(32), .NUM_REGISTERS(32)) bus ();
  div_unit #(.DATA_WIDTH(32), .NUM_REGISTERS(32)) dut (
    .clk(clk), .arst_n(arst_n), .flush_in(flush_in), .bus(bus.slave)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (arst_n && bus.valid_out && bus.ready_in && !flush_in) begin
      if (sb.size() == 0) chk("unexpected result", 32'(sb.size()), 1);
      else begin
        mon_e = sb.pop_front();
        chk("result", bus.result_out, mon_e[36:5]);
        chk("rd", 32'(bus.rd_out), 32'(mon_e[4:0]));
      end
    end
  task automatic send(input div_op_t op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int n = 0;
    while (!bus.ready_out && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready before request", 32'(bus.ready_out), 1);
    bus.valid_in = 1'b1;
    bus.op_in = op;
    bus.rs1_data_in = a;
    bus.rs2_data_in = b;
    bus.rd_in = rd;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    bus.op_in = 2'(~op);
    bus.rs1_data_in = 32'hDEADBEEF;
    bus.rs2_data_in = 32'h0BADF00D;
    bus.rd_in = ~rd;
  endtask
  task automatic wait_valid(input string name, input int lat);
    int n = 0;
    while (!bus.valid_out && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 32'(n), 32'(lat));
  endtask
  task automatic issue(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int lat);
    send(op, a, b, rd);
    sb.push_back({exp, rd});
    wait_valid("latency", lat);
    @(posedge clk); #1;
  endtask
  task automatic watch_quiet(input string name);
    int nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid_out) nv++;
    end
    chk(name, 32'(nv), 0);
    @(posedge clk); #1;
  endtask
  initial begin
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    bus.op_in = 2'b00;
    bus.rs1_data_in = '0;
    bus.rs2_data_in = '0;
    bus.rd_in = '0;
    #3;
    chk("reset ready_out", 32'(bus.ready_out), 1);
    chk("reset valid_out", 32'(bus.valid_out), 0);
    chk("reset result_out", bus.result_out, 0);
    chk("reset rd_out", 32'(bus.rd_out), 0);
    #20 arst_n = 1'b1;
    @(posedge clk); #1;
    issue(DIV, 32'd20, 32'd3, 5'd5, 32'd6, 32);
    issue(REMU, 32'd20, 32'd3, 5'd6, 32'd2, 32);
    issue(REM, 32'hFFFFFFEC, 32'd3, 5'd7, 32'hFFFFFFFE, 32);
    issue(DIV, 32'hFFFFFFEC, 32'd3, 5'd8, 32'hFFFFFFFA, 32);
    issue(DIV, 32'd7, 32'hFFFFFFFE, 5'd9, 32'hFFFFFFFD, 32);
    issue(REM, 32'd7, 32'hFFFFFFFE, 5'd10, 32'd1, 32);
    issue(DIVU, 32'h1234, 32'd0, 5'd11, 32'hFFFFFFFF, SPL);
    issue(REMU, 32'h1234, 32'd0, 5'd12, 32'h1234, SPL);
    issue(DIV, 32'hFFFFFFF9, 32'd0, 5'd13, 32'hFFFFFFFF, SPL);
    issue(REM, 32'hFFFFFFF9, 32'd0, 5'd14, 32'hFFFFFFF9, SPL);
    issue(DIV, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, SPL);
    issue(REM, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0, SPL);
    issue(DIVU, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0, 32);
    issue(REMU, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 32);
    issue(DIVU, 32'hFFFFFFFF, 32'd1, 5'd31, 32'hFFFFFFFF, 32);
    bus.ready_in = 1'b0;
    send(DIV, 32'd20, 32'd3, 5'd5);
    sb.push_back({32'd6, 5'd5});
    wait_valid("hold latency", 32);
    bus.valid_in = 1'b1;
    bus.op_in = DIVU;
    bus.rs1_data_in = 32'd100;
    bus.rs2_data_in = 32'd7;
    bus.rd_in = 5'd9;
    repeat (10) begin
      @(posedge clk); #1;
      chk("hold result_out", bus.result_out, 32'd6);
      chk("hold rd_out", 32'(bus.rd_out), 32'd5);
      chk("hold ready_out", 32'(bus.ready_out), 0);
      chk("hold valid_out", 32'(bus.valid_out), 1);
    end
    bus.ready_in = 1'b1;
    @(posedge clk); #1;
    chk("handoff ready_out", 32'(bus.ready_out), 1);
    chk("handoff valid_out", 32'(bus.valid_out), 0);
    sb.push_back({32'd14, 5'd9});
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    chk("accept after handoff", 32'(bus.ready_out), 0);
    wait_valid("post-hold latency", 32);
    @(posedge clk); #1;
    send(DIV, 32'd20, 32'd3, 5'd3);
    repeat (9) @(posedge clk);
    #1 flush_in = 1'b1;
    @(posedge clk); #1;
    flush_in = 1'b0;
    chk("flush ready_out", 32'(bus.ready_out), 1);
    chk("flush valid_out", 32'(bus.valid_out), 0);
    watch_quiet("valid after flush");
    issue(DIVU, 32'd100, 32'd7, 5'd7, 32'd14, 32);
    send(DIV, 32'd20, 32'd3, 5'd4);
    repeat (5) @(posedge clk);
    #2 arst_n = 1'b0;
    #1;
    chk("arst ready_out", 32'(bus.ready_out), 1);
    chk("arst valid_out", 32'(bus.valid_out), 0);
    chk("arst result_out", bus.result_out, 0);
    chk("arst rd_out", 32'(bus.rd_out), 0);
    #3 arst_n = 1'b1;
    watch_quiet("valid after reset");
    issue(DIVU, 32'd100, 32'd7, 5'd8, 32'd14, 32);
    repeat (3) @(posedge clk);
    chk("scoreboard drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
